// File: rtl/seg7_pkg.sv
// Shared types and constants for the scanned 4-digit 7-segment display.
//   conv_state_t : binary-to-BCD converter states
//   NDIG         : number of multiplexed digits
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit, shown on every digit when out of range
//   BCD_MAX      : largest value that fits in NDIG decimal digits
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    localparam int NDIG = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam int BCD_MAX = 9999;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern.
//   digit : 4-bit BCD code (10..15 are invalid and give a dark digit)
//   seg   : segments a..g on seg[6:0], 0 = lit
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scanned 4-digit 7-segment display controller.
// A binary value is accepted with load (only while idle), converted to BCD by
// a sequential shift-add-3 engine, then latched into the display registers.
// A refresh prescaler steps the active digit every DIV = CLK_HZ/SCAN_HZ cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   load/value : conversion request and binary operand
//   blank_lz   : blank leading zeros (units digit always shown)
//   busy       : conversion in progress
//   done       : one-cycle pulse after the display registers update
//   overflow   : last latched value exceeded 9999 (all digits show a dash)
//   an, seg    : active-low anode enables (an[0] = units) and segments a..g
module display_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int BW  = 4 * NDIG;

    conv_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]    disp_q, disp_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;

    logic [BW-1:0]    bcd_adj;
    logic [NDIG-1:0]  blank_vec;
    logic [3:0]       digit_mux;
    logic [6:0]       seg_raw;
    logic             tick;

    // Add-3 correction applied to every nibble before each shift.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end

    // A digit is a leading zero when it and every higher digit are zero.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = blank_lz & ~overflow_q &
                                   (disp_q[BW-1:4*gi] == '0);
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d    = value;
                    bcd_d      = '0;
                    cnt_d      = CW'(WIDTH);
                    ovf_pend_d = (32'(value) > BCD_MAX);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d = cnt_q - CW'(1);
                // Last of the WIDTH shifts happens on this edge.
                if (cnt_q == CW'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                disp_d     = bcd_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Refresh prescaler and scan index run independently of the converter.
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    assign digit_mux = disp_q[4*idx_q +: 4];

    bcd_to_seg7 u_seg (
        .digit (digit_mux),
        .seg   (seg_raw)
    );

    always_comb begin
        an  = blank_vec[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
        seg = overflow_q ? SEG_DASH : seg_raw;
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV = 4).
// Reference model: latency-based conversion tracking, decimal digits by
// division, scan position from the edge count since reset.
module tb_display_scan_ctrl;

    localparam int WIDTH   = 14;
    localparam int CLK_HZ  = 8;
    localparam int SCAN_HZ = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             blank_lz = 1'b0;
    logic             busy, done, overflow;
    logic [3:0]       an;
    logic [6:0]       seg;

    display_scan_ctrl #(
        .WIDTH   (WIDTH),
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int gcyc     = 0;   // edges seen
    int n_scan   = 0;   // edges since reset released
    int m_val    = 0;   // value currently displayed
    bit m_ovf    = 0;
    bit m_done   = 0;
    bit pend     = 0;   // conversion in flight
    int pend_at  = 0;   // edge at which it lands on the display
    int pend_val = 0;

    logic [6:0] seg_tab [10];
    int         pow10 [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, gcyc);
        end
    endtask

    task automatic check_all();
        int idx;
        int dig;
        idx = (n_scan / DIV) % 4;
        dig = (m_val / pow10[idx]) % 10;
        chk("busy", 32'(busy), 32'(pend));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_ovf) begin
            chk("an_ovf", 32'(an), 32'(~(4'b0001 << idx) & 4'hF));
            chk("seg_dash", 32'(seg), 32'(7'b1111110));
        end else if (blank_lz && idx > 0 && m_val < pow10[idx]) begin
            chk("an_blank", 32'(an), 32'(4'b1111));
        end else begin
            chk("an", 32'(an), 32'(~(4'b0001 << idx) & 4'hF));
            chk("seg", 32'(seg), 32'(seg_tab[dig]));
        end
    endtask

    // One clock edge: advance the model using the inputs present at the edge,
    // then compare outputs 1 time unit later.
    task automatic cycle();
        bit acc;
        @(posedge clk);
        gcyc++;
        m_done = 0;
        if (!rst_n) begin
            n_scan = 0; m_val = 0; m_ovf = 0; pend = 0;
        end else begin
            n_scan++;
            acc = load && !pend;
            if (pend && gcyc == pend_at) begin
                m_val  = pend_val;
                m_ovf  = (pend_val > 9999);
                pend   = 0;
                m_done = 1;
            end
            if (acc) begin
                pend     = 1;
                pend_at  = gcyc + WIDTH + 1;
                pend_val = int'(value);
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_load(input int v);
        load  = 1'b1;
        value = WIDTH'(v);
        $display("[TB] load value=%0d blank_lz=%0d busy_model=%0d", v, blank_lz, pend);
        cycle();
        load  = 1'b0;
        value = WIDTH'($urandom_range(0, 16383));
    endtask

    // Runs until the model's done cycle; bounded.
    task automatic wait_done();
        int k;
        k = 0;
        while (!m_done && k < 40) begin
            cycle();
            k++;
        end
        if (!m_done) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int v;
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
        pow10[0] = 1; pow10[1] = 10; pow10[2] = 100; pow10[3] = 1000;

        // Reset for 2 cycles
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // 1234 then one full frame
        pulse_load(1234);
        wait_done();
        idle(4 * DIV + 2);

        // Leading-zero blanking on and off
        blank_lz = 1'b1;
        pulse_load(7);
        wait_done();
        idle(4 * DIV);
        blank_lz = 1'b0;
        idle(4 * DIV);

        // Overflow, then back in range
        blank_lz = 1'b1;
        pulse_load(10000);
        wait_done();
        idle(4 * DIV);
        pulse_load(5);
        wait_done();
        idle(4 * DIV);
        blank_lz = 1'b0;

        // Load while busy is ignored; load in the done cycle is accepted
        pulse_load(42);
        idle(2);
        pulse_load(99);
        wait_done();
        pulse_load(99);
        wait_done();
        idle(4 * DIV);

        // Reset mid-conversion
        pulse_load(1234);
        idle(4);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(20);

        // Randomized loads
        for (int t = 0; t < 25; t++) begin
            blank_lz = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(0, 9999);
                default: v = $urandom_range(9990, 16383);
            endcase
            pulse_load(v);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(0, 10));
                pulse_load($urandom_range(0, 16383));
            end
            if ($urandom_range(0, 6) == 0) begin
                idle($urandom_range(0, 12));
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                wait_done();
            end
            idle($urandom_range(0, 2 * 4 * DIV));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the 4-digit multiplexed 7-segment display. It accepts a binary value through a load/busy/done handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto shared active-low segment and anode lines using an internal refresh prescaler. It sits between the Gray-decode datapath and the board display pins, and replaces the fixed unit/tens digit pair with a general scanned display.

## Interface
- WIDTH, 14: binary input width; maximum value 16383.
- CLK_HZ, 100_000_000: clock frequency.
- SCAN_HZ, 1000: per-digit refresh rate; DIV = CLK_HZ/SCAN_HZ, which must be ≥ 2.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  request conversion of value; sampled only in IDLE.
- value  in  WIDTH  binary value to display.
- blank_lz  in  1  1 = blank leading zeros; digit 0 is never blanked.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: display registers updated.
- overflow  out  1  last latched value was > 9999.
- an  out  4  anode enables, active-low; an[0] = units digit.
- seg  out  7  segments, active-low; seg[6:0] = a,b,c,d,e,f,g.

## Operation
- Converter FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - load=1 captures value into the shift register and clears the 16-bit BCD scratch.
  - Sets bit counter = WIDTH.
  - Registers ovf_pend = (value > 9999).
  - Next state is SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, shreg} shifts left by 1.
  - Counter decrements.
  - Leaves for LATCH after WIDTH shift cycles.
- LATCH:
  - Copies the BCD scratch into disp[3:0] and ovf_pend into overflow.
  - Asserts done on the following cycle.
  - Returns to IDLE.
- busy = (state != IDLE).
- load is ignored while busy; there is no queuing.
- Scan logic:
  - Prescaler counts 0..DIV-1; tick when count == DIV-1, then wrap to 0.
  - On tick, idx increments 0→1→2→3→0.
- Anode decode:
  - an = ~(4'b0001 << idx), unless digit idx is blanked, in which case an = 4'b1111.
  - Digit i (i > 0) is blanked when blank_lz=1, overflow=0, and disp[i..3] are all zero.
- Segment decode:
  - overflow=1: seg = 7'b1111110 (dash) on every digit; blanking is disabled.
  - Otherwise seg = bcd_to_seg7(disp[idx]).
  - Digits 0..9 use the standard patterns; codes 10–15 give 7'b1111111.
- an and seg are combinational decodes of registered state only: idx, disp, overflow, blank_lz.

## Timing
- Reset values: state=IDLE, busy=0, done=0, overflow=0, disp=0, idx=0, prescaler=0.
- After reset: an=4'b1110, seg=7'b0000001 (digit "0").
- Latency, with load sampled at edge E0:
  - busy is high for the cycles following E0 through edge E(WIDTH+1), i.e. WIDTH+1 cycles.
  - disp, overflow and done are registered at E(WIDTH+1).
  - done is high for exactly the cycle after E(WIDTH+1); busy is 0 in that cycle.
- load in the done cycle is accepted because the FSM is in IDLE.
- Display update is seamless:
  - disp changes mid-scan without resetting idx or the prescaler.
  - The new value appears on the next evaluated digit.
- idx advances one cycle after the count == DIV-1 cycle. Each digit is therefore active exactly DIV cycles, for a full frame of 4·DIV cycles.
- Reset mid-conversion (rst_n=0 on any edge) aborts the conversion: no done pulse, and all registers return to reset values.
- rst_n has priority over load.

## Structure
- Package seg7_pkg holds:
  - enum conv_state_t {IDLE, SHIFT, LATCH};
  - localparam NDIG=4;
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b1111110;
  - BCD_MAX=9999.
- Sub-module bcd_to_seg7 (combinational, 4-bit in, 7-bit active-low out) is instantiated once on the muxed digit.
- Prescaler, scan index and converter FSM live in display_scan_ctrl.

## Test plan
Tests override CLK_HZ=8, SCAN_HZ=2, so DIV=4.
- Reset: hold rst_n=0 for 2 cycles → an=1110, seg=0000001, busy=0, done=0, overflow=0.
- Load value=1234 → busy high for 15 cycles, done pulses once on the 15th cycle after the load edge.
  - The following frame shows an=1110/1101/1011/0111 with seg=1001100/0000110/0010010/1001111, each for 4 cycles.
- blank_lz=1, load value=7 → digit 0 shows an=1110, seg=0001111; digits 1–3 give an=1111.
  - Repeat with blank_lz=0 → digits 1–3 show "0".
- Load value=10000 → overflow=1, all four digits show seg=1111110.
  - Then load 5 → overflow=0, digit 0 shows "5".
- Load 42, then pulse load with 99 at cycle 3 of busy → the second load is ignored and 42 is displayed.
  - Load 99 in the done cycle → accepted, busy rises next cycle.
- Load 1234, drive rst_n=0 at busy cycle 5 → busy=0, done never pulses, display returns to "0".
